// File: rtl/pixel_frame_reader.sv
// Pops pixels from a show-ahead FIFO and re-times them into a registered valid/ready stream
// tagged with sof/eol/eof and x/y coordinates. Optional stall counter: PIXEL_READER_STALL_CNT_EN.
module pixel_frame_reader #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 64,
  parameter int unsigned IMG_H  = 64,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic [CNT_W-1:0]  out_x,
  output logic [CNT_W-1:0]  out_y,
  output logic              busy,
  output logic              frame_done,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(IMG_H - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             eof_issued;
  logic             x_last;
  logic             y_last;
  logic             frame_start;
  logic             out_accept;

  assign x_last      = (x == X_LAST);
  assign y_last      = (y == Y_LAST);
  assign frame_start = (state == ST_IDLE) && start;
  assign out_accept  = out_valid && out_ready;

  // Pop only when the output register is free or being drained this cycle.
  assign fifo_rd    = (state == ST_RUN) && !fifo_empty && !eof_issued && (!out_valid || out_ready);
  assign busy       = (state == ST_RUN);
  assign frame_done = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) state <= ST_RUN;
        ST_RUN:  if (out_accept && out_eof) state <= ST_DONE;
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x          <= '0;
      y          <= '0;
      eof_issued <= 1'b0;
    end else if (frame_start) begin
      x          <= '0;
      y          <= '0;
      eof_issued <= 1'b0;
    end else if (fifo_rd) begin
      // Counters freeze on the eof pixel; eof_issued blocks further pops.
      if (x_last && y_last) begin
        eof_issued <= 1'b1;
      end else if (x_last) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
    end else if (fifo_rd) begin
      out_valid <= 1'b1;
      out_data  <= fifo_data;
      out_sof   <= (x == '0) && (y == '0);
      out_eol   <= x_last;
      out_eof   <= x_last && y_last;
      out_x     <= x;
      out_y     <= y;
    end else if (out_accept) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
    end
  end

`ifdef PIXEL_READER_STALL_CNT_EN
  logic stall_cond;

  assign stall_cond = (state == ST_RUN) && fifo_empty && !eof_issued &&
                      (!out_valid || out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (frame_start) begin
      stall_cnt <= '0;
    end else if (stall_cond && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pixel_frame_reader.sv
// Directed bench for pixel_frame_reader (4x2 frames) with a small show-ahead FIFO model.
module tb_pixel_frame_reader;

  localparam int DATA_W = 8;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 2;
  localparam int CNT_W  = 16;
`ifdef PIXEL_READER_STALL_CNT_EN
  localparam int STALL_EXP = 3;
`else
  localparam int STALL_EXP = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_rd;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic              out_sof;
  logic              out_eol;
  logic              out_eof;
  logic [CNT_W-1:0]  out_x;
  logic [CNT_W-1:0]  out_y;
  logic              busy;
  logic              frame_done;
  logic [CNT_W-1:0]  stall_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  pixel_frame_reader #(
    .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd(fifo_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .out_x(out_x), .out_y(out_y), .busy(busy), .frame_done(frame_done),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Show-ahead FIFO model; its contents are dropped on rst like the real FIFO.
  logic [DATA_W-1:0] mem [0:31];
  logic [4:0]        rp;
  logic [4:0]        wp = '0;

  assign fifo_empty = (rp == wp);
  assign fifo_data  = mem[rp];

  always @(posedge clk or posedge rst) begin
    if (rst) rp <= wp;
    else if (fifo_rd) rp <= rp + 5'd1;
  end

  task automatic push(input logic [DATA_W-1:0] d);
    mem[wp] = d;
    wp = wp + 5'd1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_pix(input logic [7:0] d, input int ex, input int ey,
                            input logic sof, input logic eol, input logic eof);
    chk("pix_valid", 32'(out_valid), 32'd1);
    chk("pix_data", 32'(out_data), 32'(d));
    chk("pix_x", 32'(out_x), 32'(ex));
    chk("pix_y", 32'(out_y), 32'(ey));
    chk("pix_sof", 32'(out_sof), 32'(sof));
    chk("pix_eol", 32'(out_eol), 32'(eol));
    chk("pix_eof", 32'(out_eof), 32'(eof));
  endtask

  // Leaves the bench at the negedge where the block has just entered RUN.
  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
  endtask

  initial begin
    // Reset, then idle with 8 pixels queued and no start.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("idle_fifo_rd", 32'(fifo_rd), 32'd0);
      chk("idle_valid", 32'(out_valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_data", 32'(out_data), 32'd0);
      chk("idle_xy", {out_x, out_y}, 32'd0);
      chk("idle_done", 32'(frame_done), 32'd0);
      chk("idle_stall", 32'(stall_cnt), 32'd0);
    end

    // Frame 1: full-rate read of 0x10..0x17.
    do_start();
    chk("f1_rd", 32'(fifo_rd), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      expect_pix(8'(8'h10 + i), i % IMG_W, i / IMG_W, i == 0, (i % IMG_W) == IMG_W - 1, i == 7);
    end
    chk("f1_rd_after_eof", 32'(fifo_rd), 32'd0);
    @(negedge clk);
    chk("f1_frame_done", 32'(frame_done), 32'd1);
    chk("f1_valid_drop", 32'(out_valid), 32'd0);
    chk("f1_busy_done", 32'(busy), 32'd0);
    @(negedge clk);
    chk("f1_done_pulse", 32'(frame_done), 32'd0);
    chk("f1_fifo_drained", 32'(fifo_empty), 32'd1);

    // Frame 2: 10 pixels queued, backpressure while 0x12 is presented.
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    push(8'h30);
    push(8'h31);
    do_start();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_pix(8'(8'h10 + i), i, 0, i == 0, 1'b0, 1'b0);
    end
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      expect_pix(8'h12, 2, 0, 1'b0, 1'b0, 1'b0);
      chk("bp_fifo_rd", 32'(fifo_rd), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_resume_rd", 32'(fifo_rd), 32'd1);
    for (int i = 3; i < 8; i++) begin
      @(negedge clk);
      expect_pix(8'(8'h10 + i), i % IMG_W, i / IMG_W, 1'b0, (i % IMG_W) == IMG_W - 1, i == 7);
    end
    chk("f2_rd_after_eof", 32'(fifo_rd), 32'd0);
    @(negedge clk);
    chk("f2_frame_done", 32'(frame_done), 32'd1);
    chk("f2_rd_done", 32'(fifo_rd), 32'd0);
    repeat (2) @(negedge clk);
    chk("f2_left_in_fifo", 32'(wp - rp), 32'd2);

    // Frame 3: leftovers start the frame, then 3 starved cycles mid-line.
    do_start();
    @(negedge clk);
    expect_pix(8'h30, 0, 0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    expect_pix(8'h31, 1, 0, 1'b0, 1'b0, 1'b0);
    chk("starve_rd", 32'(fifo_rd), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("starve_valid", 32'(out_valid), 32'd0);
    end
    for (int i = 2; i < 8; i++) push(8'(8'h30 + i));
    #1;
    chk("starve_resume_rd", 32'(fifo_rd), 32'd1);
    for (int i = 2; i < 8; i++) begin
      @(negedge clk);
      expect_pix(8'(8'h30 + i), i % IMG_W, i / IMG_W, 1'b0, (i % IMG_W) == IMG_W - 1, i == 7);
    end
    @(negedge clk);
    chk("f3_frame_done", 32'(frame_done), 32'd1);
    chk("f3_stall_cnt", 32'(stall_cnt), 32'(STALL_EXP));
    @(negedge clk);
    chk("f3_stall_hold", 32'(stall_cnt), 32'(STALL_EXP));

    // Frame 4: reset asserted after 0x14 is accepted.
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    do_start();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      expect_pix(8'(8'h10 + i), i % IMG_W, i / IMG_W, i == 0, (i % IMG_W) == IMG_W - 1, 1'b0);
    end
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_xy", {out_x, out_y}, 32'd0);
    chk("rst_flags", {29'd0, out_sof, out_eol, out_eof}, 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_rd", 32'(fifo_rd), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    push(8'h40);
    repeat (3) @(negedge clk);
    chk("post_rst_idle_busy", 32'(busy), 32'd0);
    chk("post_rst_idle_rd", 32'(fifo_rd), 32'd0);
    do_start();
    @(negedge clk);
    expect_pix(8'h40, 0, 0, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
